// File: rtl/game_mode_ctrl_if.sv
// Button, play-logic and display-facing signals of the game flow controller.
// The master side is whatever drives the buttons and consumes mode/start.
interface game_mode_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_enter;
  logic       game_over;
  logic [2:0] mode;
  logic       btn_mode_sel;
  logic       game_start;

  modport master (
    output btn_up, btn_down, btn_enter, game_over,
    input  mode, btn_mode_sel, game_start
  );

  modport slave (
    input  btn_up, btn_down, btn_enter, game_over,
    output mode, btn_mode_sel, game_start
  );
endinterface

// File: rtl/game_mode_ctrl.sv
// Game flow controller: debounces the three player buttons, keeps the start-menu
// cursor and sequences start screen -> play -> game over -> start screen.
module game_mode_ctrl #(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int GAMEOVER_HOLD = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  game_mode_ctrl_if.slave  bus
);

  localparam logic [2:0] MODE0 = 3'd0;
  localparam logic [2:0] MODE1 = 3'd1;
  localparam logic [2:0] MODE2 = 3'd2;
  localparam logic [2:0] MODE3 = 3'd3;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(GAMEOVER_HOLD);

  // Bit order everywhere: [0] up, [1] down, [2] enter.
  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d, deb_prev_q, press_q;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]            mode_q, mode_d;
  logic                  sel_q, sel_d;
  logic [CNT_W-1:0]      hold_q, hold_d;

  assign raw = {bus.btn_enter, bus.btn_down, bus.btn_up};

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      deb_prev_q <= deb_q;
      // Rising edges only: a release never produces an event.
      press_q    <= deb_q & ~deb_prev_q;
    end
  end

  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    hold_d = '0;
    case (mode_q)
      MODE0: begin
        if (press_q[2]) begin
          mode_d = sel_q ? MODE1 : MODE2;
        end else if (press_q[0] && !press_q[1]) begin
          sel_d = 1'b1;
        end else if (press_q[1] && !press_q[0]) begin
          sel_d = 1'b0;
        end
      end
      MODE1, MODE2: begin
        if (bus.game_over) begin
          mode_d = MODE3;
        end
      end
      MODE3: begin
        // Enter is only honoured once the hold time has fully elapsed.
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);
        if (press_q[2] && hold_q == HOLD_MAX) begin
          mode_d = MODE0;
          sel_d  = 1'b1;
        end
      end
      default: mode_d = MODE0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE0;
      sel_q  <= 1'b1;
      hold_q <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      hold_q <= hold_d;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.btn_mode_sel = sel_q;
  assign bus.game_start   = (mode_q == MODE0) && press_q[2];

endmodule

// File: doc/game_mode_ctrl.md
Name: game_mode_ctrl

Overview:
- Top-level game flow controller, directly upstream of the interface/display stage.
- Debounces the three player buttons and maintains the start-menu cursor selection, which drives btn_mode_sel.
- Sequences the game mode and drives mode[2:0]: 0 = start screen, 1 = option A play, 2 = option B play, 3 = game over.
- Consumes a game_over flag from the play logic and issues a one-cycle game_start pulse to reset play state.

Parameters:
DEBOUNCE_CYC, 250000, consecutive stable cycles required before a debounced button level changes (10 ms at 25 MHz).
GAMEOVER_HOLD, 50000000, cycles mode 3 is held before enter is accepted (2 s at 25 MHz).
CNT_W, 26, width of the debounce and hold counters. Must satisfy 2^CNT_W > max(DEBOUNCE_CYC, GAMEOVER_HOLD).

Ports:
clk  input  1  system/pixel clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_up  input  1  raw asynchronous button, 1 = pressed
btn_down  input  1  raw asynchronous button, 1 = pressed
btn_enter  input  1  raw asynchronous button, 1 = pressed
game_over  input  1  level from play logic, synchronous to clk, 1 = player lost
mode  output  3  current game mode, registered
btn_mode_sel  output  1  cursor selection, registered: 1 = upper option (mode 1), 0 = lower option (mode 2)
game_start  output  1  one-cycle pulse on entry to mode 1 or 2

Behaviour:

Reset (rst_n=0, asynchronous):
- mode=0, btn_mode_sel=1, game_start=0.
- Synchronizers, debounced levels, debounce counters and hold counter all cleared to 0.
- Reset asserted mid-game forces mode 0 immediately, with no game_start pulse.

Debounce (per button, three identical instances):
- 2-flop synchronizer feeds the debounce logic.
- Whenever the synchronized value equals the debounced level, the counter is cleared.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1 and the value still differs, the debounced level takes the synchronized value and the counter clears.
- press_x is a registered one-cycle pulse on a 0->1 transition of the debounced level. Releases produce no event.
- Glitches shorter than DEBOUNCE_CYC cycles produce no event.
- Latency: raw 1 first sampled at edge k -> press pulse high during cycle k+DEBOUNCE_CYC+2 -> mode/btn_mode_sel updated at edge k+DEBOUNCE_CYC+3.

FSM (state encoding equals mode value):
- MODE0 (start screen):
  - press_up alone -> btn_mode_sel=1.
  - press_down alone -> btn_mode_sel=0.
  - press_up and press_down in the same cycle -> no change.
  - press_enter -> mode = btn_mode_sel ? 1 : 2 and game_start=1 for that one cycle. Enter uses the pre-update btn_mode_sel; any up/down in the same cycle is ignored.
  - game_over is ignored.
- MODE1 / MODE2 (play):
  - game_over=1 sampled -> mode=3, hold counter cleared.
  - All buttons are ignored; btn_mode_sel is frozen.
- MODE3 (game over):
  - Hold counter increments and saturates at GAMEOVER_HOLD.
  - press_enter while counter < GAMEOVER_HOLD is ignored; it is not queued.
  - press_enter once counter == GAMEOVER_HOLD -> mode=0, btn_mode_sel=1.
  - game_over level is ignored; up/down are ignored.
- Values 4..7 are never produced. If reached through an upset, the next edge returns to mode 0.

Outputs:
- game_start is high only in the cycle the mode register leaves 0; otherwise 0.
- mode and btn_mode_sel are glitch-free registered outputs.

Test Plan:
Bench uses DEBOUNCE_CYC=4, GAMEOVER_HOLD=16, CNT_W=5.
- Reset: hold rst_n=0, then release -> mode=0, btn_mode_sel=1, game_start=0. Assert rst_n=0 while mode=2 -> mode=0 asynchronously, before the next clock edge.
- Debounce: btn_down high for 3 cycles then low -> no change. btn_down high for 10 cycles -> btn_mode_sel=0 exactly 7 edges after first sampled high, then stays 0. A 1-cycle low glitch during the hold produces no second event.
- Start: btn_mode_sel=0, press enter -> mode=2 with game_start=1 for exactly 1 cycle. Repeat with btn_mode_sel=1 -> mode=1.
- Simultaneous events: up and down pressed on the same cycle in mode 0 -> btn_mode_sel unchanged. Up and enter on the same cycle with btn_mode_sel=0 -> mode=2.
- Game over: in mode 1 raise game_over -> mode=3 next edge. Enter pressed 5 cycles later is ignored and mode stays 3. Enter after 16 hold cycles -> mode=0, btn_mode_sel=1.
- Play isolation: in mode 2, press up, down and enter -> mode stays 2, btn_mode_sel unchanged, game_start stays 0. In mode 0, game_over=1 -> no change.
